// File: rtl/step_counter_pkg.sv
// Shared defaults and the update-select encoding for step_counter.
package step_counter_pkg;
  localparam int DEF_WIDTH     = 10;
  localparam int DEF_RESET_VAL = -50;
  localparam int DEF_MIN       = -230;
  localparam int DEF_MAX       = 235;
  localparam int DEF_STEP_UP   = 5;
  localparam int DEF_STEP_DN   = 9;
  localparam int DEF_INV       = -11;

  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_LOAD,
    UPD_STEP,
    UPD_ERR
  } upd_e;
endpackage

// File: rtl/step_counter_next.sv
// Combinational next-value unit: one step, INV skip, then bound policy.
// Bound policy: wrap when STEP_COUNTER_WRAP_EN is defined, saturate otherwise.
module step_counter_next
  import step_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MIN     = DEF_MIN,
  parameter int MAX     = DEF_MAX,
  parameter int STEP_UP = DEF_STEP_UP,
  parameter int STEP_DN = DEF_STEP_DN,
  parameter int INV     = DEF_INV
) (
  input  logic signed [WIDTH-1:0] cnt,
  input  logic                    mode,
  output logic signed [WIDTH-1:0] nxt,
  output logic                    skip_hit,
  output logic                    bnd_hit
);
  // Two guard bits so cnt plus two steps never overflows.
  localparam int XW = WIDTH + 2;
  localparam logic signed [XW-1:0]    UP_X  = XW'(STEP_UP);
  localparam logic signed [XW-1:0]    DN_X  = XW'(-STEP_DN);
  localparam logic signed [XW-1:0]    MIN_X = XW'(MIN);
  localparam logic signed [XW-1:0]    MAX_X = XW'(MAX);
  localparam logic signed [XW-1:0]    INV_X = XW'(INV);
  localparam logic signed [WIDTH-1:0] MIN_W = WIDTH'(MIN);
  localparam logic signed [WIDTH-1:0] MAX_W = WIDTH'(MAX);
`ifdef STEP_COUNTER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic signed [XW-1:0] cur;
  logic signed [XW-1:0] step;
  logic signed [XW-1:0] raw;
  logic signed [XW-1:0] adv;

  always_comb begin
    cur      = {{2{cnt[WIDTH-1]}}, cnt};
    step     = mode ? UP_X : DN_X;
    raw      = cur + step;
    skip_hit = (raw == INV_X);
    adv      = skip_hit ? raw + step : raw;
    bnd_hit  = 1'b0;
    nxt      = adv[WIDTH-1:0];
    if (adv > MAX_X) begin
      bnd_hit = 1'b1;
      nxt     = WRAP ? MIN_W : MAX_W;
    end else if (adv < MIN_X) begin
      bnd_hit = 1'b1;
      nxt     = WRAP ? MAX_W : MIN_W;
    end
  end
endmodule

// File: rtl/step_counter.sv
// Signed up/down step counter with enable, range-checked load and INV skip.
// Bound policy selected in step_counter_next by STEP_COUNTER_WRAP_EN.
module step_counter
  import step_counter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int RESET_VAL = DEF_RESET_VAL,
  parameter int MIN       = DEF_MIN,
  parameter int MAX       = DEF_MAX,
  parameter int STEP_UP   = DEF_STEP_UP,
  parameter int STEP_DN   = DEF_STEP_DN,
  parameter int INV       = DEF_INV
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] load_val,
  output logic signed [WIDTH-1:0] cnt,
  output logic                    at_max,
  output logic                    at_min,
  output logic                    skip,
  output logic                    bnd,
  output logic                    load_err
);
  localparam logic signed [WIDTH-1:0] MIN_W   = WIDTH'(MIN);
  localparam logic signed [WIDTH-1:0] MAX_W   = WIDTH'(MAX);
  localparam logic signed [WIDTH-1:0] INV_W   = WIDTH'(INV);
  localparam logic signed [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
  localparam int LIM_LO = -(1 <<< (WIDTH - 1));
  localparam int LIM_HI = (1 <<< (WIDTH - 1)) - 1;
  localparam int STEP_MAX = (STEP_UP > STEP_DN) ? STEP_UP : STEP_DN;

  if (!(MIN < RESET_VAL && RESET_VAL <= MAX)) begin : g_chk_reset_range
    $error("step_counter: RESET_VAL outside (MIN, MAX]");
  end
  if (RESET_VAL == INV) begin : g_chk_reset_inv
    $error("step_counter: RESET_VAL equals INV");
  end
  if (!(MIN < INV && INV < MAX)) begin : g_chk_inv_range
    $error("step_counter: INV outside (MIN, MAX)");
  end
  if (!(STEP_UP > 0 && STEP_DN > 0)) begin : g_chk_steps
    $error("step_counter: steps must be positive");
  end
  if (!(2 * STEP_MAX < MAX - MIN)) begin : g_chk_span
    $error("step_counter: double step does not fit inside MIN..MAX");
  end
  if (!(MIN >= LIM_LO && MAX <= LIM_HI)) begin : g_chk_fit
    $error("step_counter: MIN/MAX do not fit in WIDTH");
  end

  logic signed [WIDTH-1:0] step_nxt;
  logic                    skip_hit;
  logic                    bnd_hit;

  step_counter_next #(
    .WIDTH  (WIDTH),
    .MIN    (MIN),
    .MAX    (MAX),
    .STEP_UP(STEP_UP),
    .STEP_DN(STEP_DN),
    .INV    (INV)
  ) u_next (
    .cnt     (cnt),
    .mode    (mode),
    .nxt     (step_nxt),
    .skip_hit(skip_hit),
    .bnd_hit (bnd_hit)
  );

  upd_e                    upd;
  logic                    load_ok;
  logic signed [WIDTH-1:0] cnt_d;

  always_comb begin
    load_ok = (load_val >= MIN_W) && (load_val <= MAX_W) && (load_val != INV_W);
    upd     = UPD_HOLD;
    if (load) upd = load_ok ? UPD_LOAD : UPD_ERR;
    else if (en) upd = UPD_STEP;

    cnt_d = cnt;
    case (upd)
      UPD_LOAD: cnt_d = load_val;
      UPD_STEP: cnt_d = step_nxt;
      default:  cnt_d = cnt;
    endcase
  end

  // Flags are registered from cnt_d so they always match the cnt they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= RESET_W;
      at_max   <= (RESET_W == MAX_W);
      at_min   <= (RESET_W == MIN_W);
      skip     <= 1'b0;
      bnd      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      at_max   <= (cnt_d == MAX_W);
      at_min   <= (cnt_d == MIN_W);
      skip     <= (upd == UPD_STEP) && skip_hit;
      bnd      <= (upd == UPD_STEP) && bnd_hit;
      load_err <= (upd == UPD_ERR);
    end
  end
endmodule

// File: doc/step_counter.md
# step_counter

Parametrised signed up/down step counter generalising the team's fixed-step mode counter. Counting steps, bounds, reset value and the forbidden value are set by parameters. The block adds an enable, a synchronous parallel load with range checking, and a selectable saturate/wrap policy at the bounds. It sits as a leaf under formal and simulation benches in the same task area and is intended to be bound to an assertion module.

## Interface
- WIDTH, 10, counter width in bits (signed two's complement)
- RESET_VAL, -50, value of cnt after reset
- MIN, -230, lowest legal value
- MAX, 235, highest legal value
- STEP_UP, 5, increment applied when mode=1
- STEP_DN, 9, decrement magnitude applied when mode=0
- INV, -11, forbidden value that cnt must never take

- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  count enable
- mode  input  1  1 = count up, 0 = count down
- load  input  1  parallel load request
- load_val  input  WIDTH signed  value to load
- cnt  output  WIDTH signed  counter value
- at_max  output  1  cnt == MAX
- at_min  output  1  cnt == MIN
- skip  output  1  one-cycle pulse: last update jumped over INV
- bnd  output  1  one-cycle pulse: last update hit a bound (saturated or wrapped)
- load_err  output  1  one-cycle pulse: last load was rejected

## Operation
- Priority in each cycle: rst > load > en > hold.
- rst: cnt=RESET_VAL; skip, bnd and load_err are cleared; at_max and at_min follow cnt.
- load: if MIN<=load_val<=MAX and load_val!=INV, then cnt=load_val. Otherwise cnt holds and load_err=1. A load ignores en and mode.
- en with mode=1: nxt=cnt+STEP_UP. With mode=0: nxt=cnt-STEP_DN.
- INV skip: if nxt==INV, nxt is advanced by one more step in the same direction (cnt±2·step) and skip=1.
- Bound check runs after the skip. If nxt>MAX or nxt<MIN, the bound policy applies (see Configuration) and bnd=1.
- Landing exactly on MAX or MIN is legal and does not set bnd.
- Hold (no rst, no load, no en): cnt unchanged; all pulse outputs are 0.
- All arithmetic is done at WIDTH+2 signed bits, so intermediate results never overflow.
- Mode may change on any cycle. The block keeps no direction history.
- Elaboration-time checks, each issuing $error on failure:
  - MIN<RESET_VAL<=MAX
  - RESET_VAL!=INV
  - MIN<INV<MAX
  - STEP_UP>0 and STEP_DN>0
  - 2·max(STEP_UP,STEP_DN) < MAX-MIN
  - MIN and MAX fit in WIDTH

## Timing
- All outputs are registered; latency is 1 cycle from input sample to cnt update.
- skip, bnd and load_err are valid in the same cycle as the cnt update they describe, and are high for exactly one cycle.
- at_max and at_min are registered together with cnt and are never stale.
- rst asserted mid-count takes effect on the next edge, regardless of load or en.
- Invariant in every non-reset cycle: MIN<=cnt<=MAX and cnt!=INV.

## Configuration
- Macro STEP_COUNTER_WRAP_EN selects the bound policy.
- Defined (wrap): up overflow gives cnt=MIN; down underflow gives cnt=MAX.
- Undefined (saturate, default): up overflow gives cnt=MAX; down underflow gives cnt=MIN.
- bnd is pulsed in both builds.

## Structure
- Package step_counter_pkg holds:
  - default parameter constants (DEF_WIDTH, DEF_MIN, DEF_MAX, DEF_STEP_UP, DEF_STEP_DN, DEF_INV, DEF_RESET_VAL)
  - enum upd_e {UPD_HOLD, UPD_LOAD, UPD_STEP, UPD_ERR}, used for the internal update select
- One sub-module, step_counter_next: combinational next-value unit.
  - Inputs: cnt, mode.
  - Outputs: nxt, skip_hit, bnd_hit.
  - Contains the INV skip and the bound policy.
- The top module holds the registers, priority logic and load checking.

## Test plan
All cases use default parameters.
- Reset for 1 cycle, then release → cnt=-50, at_max=0, at_min=0, all pulses 0.
- Load -21, en=1, mode=1 → -16, then -6 with skip=1.
- Load 7, mode=0 → -2, then -20 with skip=1. cnt is never -11.
- Load 230, mode=1 → 235 with at_max=1 and bnd=0. Next step → 235 and bnd=1 (saturate build), or -230 and bnd=1 (wrap build).
- Load -225, mode=0 → -230 with bnd=1 and at_min=1 (saturate build), or 235 (wrap build).
- Load -11 → cnt holds, load_err=1. Load 300 → cnt holds, load_err=1. rst and load asserted together → cnt=-50, load_err=0.
